// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide, one bit per cycle (shift-add / restoring divide).
// Optional MDU_FAST_SPECIAL_EN: special-case operands skip the iteration and complete in one cycle.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             res_valid_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int CW = $clog2(WIDTH) + 1;
`ifdef MDU_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;

    logic [2:0]       op;
    logic [WIDTH-1:0] mag_a, mag_b, hi, lo, hi_nx, lo_nx, ld_val;
    logic [WIDTH:0]   sum, sh;
    logic [CW-1:0]    cnt;
    logic             neg_a, neg_b, dz, ovf, mz, ge, last, ld, fast_go;
    logic             in_sa, in_sb, in_dz, in_ovf, in_mz;
    logic [WIDTH-1:0] in_ma, in_mb;

    // Sign handling: signed dividend/rs1 for all but MULHU/DIVU/REMU; rs2 additionally unsigned for MULHSU.
    assign in_sa  = src1_i[WIDTH-1] & (op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11));
    assign in_sb  = src2_i[WIDTH-1] & (op_i[2] ? ~op_i[0] : ~op_i[1]);
    assign in_ma  = in_sa ? -src1_i : src1_i;
    assign in_mb  = in_sb ? -src2_i : src2_i;
    assign in_dz  = op_i[2] & (src2_i == '0);
    assign in_ovf = op_i[2] & ~op_i[0] & (src1_i == MIN_INT) & (&src2_i);
    assign in_mz  = ~op_i[2] & ((src1_i == '0) | (src2_i == '0));
    assign fast_go = FAST & (in_dz | in_ovf | in_mz);

    // Final sign correction and RISC-V special-case results; h/l hold product halves or remainder/quotient.
    function automatic logic [WIDTH-1:0] fin(input logic [2:0] o, input logic na, input logic nb,
                                             input logic [WIDTH-1:0] ma, input logic z, input logic v,
                                             input logic m, input logic [WIDTH-1:0] h,
                                             input logic [WIDTH-1:0] l);
        logic [2*WIDTH-1:0] p;
        logic [WIDTH-1:0]   q, r;
        p = (na ^ nb) ? -{h, l} : {h, l};
        q = (na ^ nb) ? -l : l;
        r = na ? -h : h;
        if (z) return o[1] ? (na ? -ma : ma) : '1;
        if (v) return o[1] ? '0 : MIN_INT;
        if (m) return '0;
        return o[2] ? (o[1] ? r : q) : ((o[1:0] == 2'b00) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH]);
    endfunction

    assign sum   = {1'b0, hi} + {1'b0, lo[0] ? mag_a : '0};
    assign sh    = {hi, lo[WIDTH-1]};
    assign ge    = sh >= {1'b0, mag_b};
    assign hi_nx = op[2] ? (ge ? WIDTH'(sh - {1'b0, mag_b}) : sh[WIDTH-1:0]) : sum[WIDTH:1];
    assign lo_nx = op[2] ? {lo[WIDTH-2:0], ge} : {sum[0], lo[WIDTH-1:1]};
    assign last  = cnt == CW'(WIDTH - 1);

    assign busy_o      = state != IDLE;
    assign res_valid_o = state == DONE;

    always_comb begin
        state_nx = state;
        ld       = 1'b0;
        ld_val   = '0;
        case (state)
            IDLE: if (start_i && !flush_i) begin
                state_nx = fast_go ? DONE : CALC;
                ld       = fast_go;
                ld_val   = fin(op_i, in_sa, in_sb, in_ma, in_dz, in_ovf, in_mz, '0, '0);
            end
            CALC: begin
                state_nx = flush_i ? IDLE : (last ? DONE : CALC);
                ld       = !flush_i && last;
                ld_val   = fin(op, neg_a, neg_b, mag_a, dz, ovf, mz, hi_nx, lo_nx);
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op       <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            dz       <= 1'b0;
            ovf      <= 1'b0;
            mz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            result_o <= '0;
        end else begin
            if (state == IDLE && start_i && !flush_i) begin
                op    <= op_i;
                mag_a <= in_ma;
                mag_b <= in_mb;
                neg_a <= in_sa;
                neg_b <= in_sb;
                dz    <= in_dz;
                ovf   <= in_ovf;
                mz    <= in_mz;
                hi    <= '0;
                lo    <= op_i[2] ? in_ma : in_mb;
                cnt   <= '0;
            end else if (state == CALC) begin
                hi  <= hi_nx;
                lo  <= lo_nx;
                cnt <= cnt + 1'b1;
            end
            if (ld) result_o <= ld_val;
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: vector table, randomized ops against an arithmetic model, flush/reset sequences.
module tb_mdu_iter;
    localparam int W = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic clk = 0, rst = 0, start_i = 0, flush_i = 0;
    logic [2:0]  op_i = 0;
    logic [W-1:0] src1_i = 0, src2_i = 0;
    logic busy_o, res_valid_o;
    logic [W-1:0] result_o;
    int checks = 0, failures = 0;
    logic [31:0] last_exp = 0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .src1_i(src1_i), .src2_i(src2_i),
        .flush_i(flush_i), .busy_o(busy_o), .res_valid_o(res_valid_o), .result_o(result_o)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: 64-bit products of extended operands, native signed/unsigned division.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, p;
        longint sa, sb;
        if (!op[2]) begin
            xa = (op != 3'b011) ? {{32{a[31]}}, a} : {32'b0, a};
            xb = (op[1] == 1'b0) ? {{32{b[31]}}, b} : {32'b0, b};
            p = xa * xb;
            return (op == 3'b000) ? p[31:0] : p[63:32];
        end
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == MIN && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : MIN;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sp;
        sp = op[2] ? (b == 0 || (!op[0] && a == MIN && b == 32'hFFFF_FFFF)) : (a == 0 || b == 0);
`ifdef MDU_FAST_SPECIAL_EN
        return sp ? 1 : W + 1;
`else
        return sp ? W + 1 : W + 1;
`endif
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int cyc, busy_n, lat;
        logic got;
        lat = exp_lat(op, a, b);
        op_i = op; src1_i = a; src2_i = b; start_i = 1;
        @(posedge clk); #1;
        start_i = 0; op_i = 3'($urandom); src1_i = $urandom; src2_i = $urandom;
        cyc = 0; busy_n = 0; got = 0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (busy_o) busy_n++;
            if (res_valid_o) got = 1;
        end
        chk({name, " valid"}, got, 1);
        chk({name, " result"}, result_o, exp);
        chk({name, " latency"}, cyc, lat);
        chk({name, " busy_cycles"}, busy_n, lat);
        @(negedge clk);
        chk({name, " valid_pulse"}, res_valid_o, 0);
        chk({name, " idle_after"}, busy_o, 0);
        chk({name, " result_held"}, result_o, exp);
        last_exp = exp;
    endtask

    task automatic quiet(input string name, input int n);
        logic seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (res_valid_o) seen = 1;
        end
        chk(name, seen, 0);
    endtask

    vec_t tv[17];

    initial begin
        tv[0]  = '{3'd5, 32'd100, 32'd7, 32'd14};
        tv[1]  = '{3'd7, 32'd100, 32'd7, 32'd2};
        tv[2]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
        tv[3]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
        tv[4]  = '{3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        tv[5]  = '{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF};
        tv[6]  = '{3'd7, 32'd5, 32'd0, 32'd5};
        tv[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tv[8]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        tv[9]  = '{3'd0, 32'h1234_5678, 32'h10, 32'h2345_6780};
        tv[10] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        tv[11] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tv[12] = '{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF};
        tv[13] = '{3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB};
        tv[14] = '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF};
        tv[15] = '{3'd0, 32'd0, 32'h1234, 32'd0};
        tv[16] = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};

        #1 rst = 1;
        #2;
        chk("reset busy", busy_o, 0);
        chk("reset valid", res_valid_o, 0);
        chk("reset result", result_o, 0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 17; i++) run_op($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].exp);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            logic [31:0] a, b;
            int r;
            op = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            r = $urandom_range(0, 7);
            if (r == 0) b = 0;
            if (r == 1) begin a = MIN; b = 32'hFFFF_FFFF; end
            if (r == 2) a = 0;
            run_op($sformatf("rand%0d", i), op, a, b, model(op, a, b));
        end

        // Flush on the 5th CALC cycle, with an ignored start raised during CALC.
        op_i = 3'd5; src1_i = 32'd1000; src2_i = 32'd3; start_i = 1;
        @(posedge clk); #1;
        start_i = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 2) begin start_i = 1; op_i = 3'd0; src1_i = 3; src2_i = 3; end
            if (c == 3) start_i = 0;
            if (c == 4) chk("flush busy_calc", busy_o, 1);
            if (c == 5) flush_i = 1;
        end
        @(negedge clk);
        flush_i = 0;
        chk("flush busy_drop", busy_o, 0);
        quiet("flush no_valid", 40);
        chk("flush result_kept", result_o, last_exp);
        run_op("after_flush", 3'd5, 32'd1000, 32'd3, 32'd333);

        // Asynchronous reset in the middle of CALC.
        op_i = 3'd4; src1_i = 32'd1000; src2_i = 32'd7; start_i = 1;
        @(posedge clk); #1;
        start_i = 0;
        repeat (10) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("rst busy", busy_o, 0);
        chk("rst valid", res_valid_o, 0);
        chk("rst result", result_o, 0);
        @(negedge clk);
        rst = 0;
        quiet("rst no_valid", 40);
        last_exp = 0;

        // flush and start together in IDLE: start dropped.
        op_i = 3'd5; src1_i = 32'd9; src2_i = 32'd2; start_i = 1; flush_i = 1;
        @(negedge clk);
        start_i = 0; flush_i = 0;
        chk("flush_start busy", busy_o, 0);
        quiet("flush_start no_valid", 40);
        run_op("final", 3'd7, 32'd9, 32'd2, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
